keypad_event_encoder: RTL and testbench



---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_event_encoder_if.sv | 9 +
 rtl/key_event_fifo.sv | 39 +++
 rtl/keypad_event_encoder.sv | 78 +++++++
 tb/tb_keypad_event_encoder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared widths, FSM state type and one-hot helpers for keypad blocks.
package keypad_pkg;
    localparam int KEY_W  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {IDLE, HELD, MULTI} key_state_t;

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

    function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_W; i++)
            if (v[i]) idx = idx | CODE_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/keypad_event_encoder_if.sv
// keypad_event_encoder_if: valid/ready key-code stream toward the calculator control logic.
interface keypad_event_encoder_if;
    import keypad_pkg::*;
    logic [CODE_W-1:0] code_data;
    logic              code_valid;
    logic              code_ready;
    modport master (output code_data, output code_valid, input code_ready);
    modport slave  (input code_data, input code_valid, output code_ready);
endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo: first-word fall-through FIFO; full pushes are ignored, pointers carry a wrap bit.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp, r_rp;
    logic         w_wr, w_rd;

    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    // a pop in the same cycle frees the slot the push needs
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_event_encoder.sv
// keypad_event_encoder: debounces the raw keypad vector, emits one code per clean single-key
// press and buffers codes in a FIFO; chords and rollovers are suppressed until full release.
module keypad_event_encoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_W-1:0]       keys,
    keypad_event_encoder_if.master evt,
    output logic                   key_held,
    output logic                   overflow
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0]  r_sample, r_deb, r_cap;
    logic [CW-1:0]     r_cnt;
    key_state_t        r_state, w_next;
    logic              w_stable, w_push, w_pop, w_full, w_empty;
    logic [CODE_W-1:0] w_code;

    assign w_stable       = keys == r_sample;
    assign w_pop          = evt.code_valid && evt.code_ready;
    assign w_code         = onehot_to_idx(r_deb);
    assign evt.code_valid = !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_cnt    <= '0;
            r_deb    <= '0;
            r_cap    <= '0;
            key_held <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r_sample <= keys;
            r_cnt    <= w_stable ? (r_cnt == CMAX ? r_cnt : r_cnt + 1'b1) : '0;
            if (w_stable && r_cnt == CMAX) r_deb <= r_sample;
            if (w_push) r_cap <= r_deb;
            key_held <= |r_deb;
            overflow <= w_push && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // only a press starting from a fully released pad can generate an event
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            IDLE: begin
                w_push = is_onehot(r_deb);
                w_next = w_push ? HELD : (r_deb != '0 ? MULTI : IDLE);
            end
            HELD:    w_next = r_deb == '0 ? IDLE : (r_deb != r_cap ? MULTI : HELD);
            MULTI:   w_next = r_deb == '0 ? IDLE : MULTI;
            default: w_next = IDLE;
        endcase
    end

    key_event_fifo #(.DEPTH(FIFO_DEPTH), .W(CODE_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_code),
        .i_pop   (w_pop),
        .o_data  (evt.code_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_keypad_event_encoder.sv
// tb_keypad_event_encoder: scoreboard bench; a run-length debounce/press model feeds expected
// codes into a queue that a negedge monitor checks against the DUT stream.
module tb_keypad_event_encoder;
    import keypad_pkg::*;
    localparam int D     = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;
    logic        key_held, overflow;

    always #5 clk = ~clk;

    keypad_event_encoder_if bus();

    keypad_event_encoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .keys     (keys),
        .evt      (bus),
        .key_held (key_held),
        .overflow (overflow)
    );

    int          tests = 0, fails = 0, ovf_seen = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  rx_q[$];
    logic [15:0] run_val = '0, d = '0, nd;
    int          run_len = 1, m_cnt = 0;
    logic        pend = 1'b0, pop, exp_held = 1'b0, exp_ovf = 1'b0;
    logic [3:0]  pend_code = '0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference: d is the input once it has been seen on D+1 consecutive edges (the reset
    // sample counts as a zero); an event is a 0 -> single-key change of d, queued one edge later.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            run_val = '0; run_len = 1; d = '0; pend = 1'b0; m_cnt = 0;
            exp_q.delete(); exp_held = 1'b0; exp_ovf = 1'b0;
        end else begin
            pop = (m_cnt > 0) && bus.code_ready;
            exp_ovf = 1'b0;
            if (pend) begin
                if (m_cnt == DEPTH && !pop) exp_ovf = 1'b1;
                else begin
                    exp_q.push_back(pend_code);
                    m_cnt++;
                end
            end
            if (pop) m_cnt--;
            exp_held = d != 0;
            if (keys == run_val) run_len++;
            else begin
                run_val = keys;
                run_len = 1;
            end
            nd = (run_len >= D + 1) ? run_val : d;
            pend = (d == 0) && ($countones(nd) == 1);
            pend_code = 4'($clog2(nd));
            d = nd;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_valid", 16'(bus.code_valid), 16'h0);
            chk("rst_data", 16'(bus.code_data), 16'h0);
            chk("rst_held", 16'(key_held), 16'h0);
            chk("rst_ovf", 16'(overflow), 16'h0);
        end else begin
            chk("valid", 16'(bus.code_valid), 16'(exp_q.size() != 0));
            chk("held", 16'(key_held), 16'(exp_held));
            chk("ovf", 16'(overflow), 16'(exp_ovf));
            if (overflow) ovf_seen++;
            if (bus.code_valid && exp_q.size() != 0) begin
                chk("data", 16'(bus.code_data), 16'(exp_q[0]));
                if (bus.code_ready) begin
                    rx_q.push_back(bus.code_data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic hold(input logic [15:0] k, input int n);
        keys = k;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string nm, input int n, input logic [15:0] codes);
        chk({nm, "_count"}, 16'(rx_q.size()), 16'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk({nm, "_code"}, 16'(rx_q[i]), 16'(codes[4*i +: 4]));
        rx_q.delete();
    endtask

    initial begin
        logic [15:0] v;
        bus.code_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        bus.code_ready = 1'b1;
        hold(16'h0020, 20);
        hold(16'h0000, 12);
        check_rx("t1_single", 1, 16'h0005);

        for (int i = 0; i < 5; i++) begin
            hold(16'h0001, 3);
            hold(16'h0000, 3);
        end
        check_rx("t2_bounce", 0, 16'h0000);
        hold(16'h0001, 14);
        hold(16'h0000, 12);
        check_rx("t2_stable", 1, 16'h0000);

        hold(16'h0003, 12);
        hold(16'h0001, 12);
        hold(16'h0000, 12);
        check_rx("t3_chord", 0, 16'h0000);
        hold(16'h0100, 12);
        hold(16'h0000, 12);
        check_rx("t3_after", 1, 16'h0008);

        hold(16'h0010, 12);
        hold(16'h0030, 12);
        hold(16'h0020, 12);
        hold(16'h0000, 12);
        check_rx("t4_rollover", 1, 16'h0004);

        bus.code_ready = 1'b0;
        ovf_seen = 0;
        for (int k = 1; k <= 5; k++) begin
            hold(16'(1 << k), 12);
            hold(16'h0000, 12);
        end
        chk("t5_ovf_pulses", 16'(ovf_seen), 16'd1);
        chk("t5_full_valid", 16'(bus.code_valid), 16'h1);
        bus.code_ready = 1'b1;
        hold(16'h0000, 10);
        check_rx("t5_drain", 4, 16'h4321);

        hold(16'h8000, 5);
        rst_n = 1'b0;
        hold(16'h8000, 3);
        rst_n = 1'b1;
        hold(16'h8000, 20);
        hold(16'h0000, 12);
        check_rx("t6_reset", 1, 16'h000F);

        repeat (60) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = 16'(1 << $urandom_range(0, 15));
                2:       v = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                default: v = 16'(1 << $urandom_range(0, 3));
            endcase
            bus.code_ready = 1'($urandom_range(0, 1));
            hold(v, $urandom_range(1, 14));
        end
        bus.code_ready = 1'b1;
        hold(16'h0000, 30);
        chk("rand_drained", 16'(bus.code_valid), 16'h0);
        rx_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
